// File: rtl/int_req_ctrl.sv
// Interrupt request source for the CU: programmable timer (c) and external pin (o) with pending, mask and lost-count logic.
// Optional build macro INT_LEVEL_EN makes the o source level-sensitive instead of edge-triggered.
module int_req_ctrl #(
  parameter int TIMER_W       = 16,
  parameter int TIMER_DEFAULT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               timer_en,
  input  logic               timer_load,
  input  logic [TIMER_W-1:0] timer_data,
  input  logic               o_irq_in,
  input  logic               c_clear,
  input  logic               o_clear,
  input  logic               c_ban,
  input  logic               c_allow,
  input  logic               o_ban,
  input  logic               o_allow,
  input  logic               lost_clr,
  output logic               c_shield_out,
  output logic               o_shield_out,
  output logic               c_pend_raw,
  output logic               o_pend_raw,
  output logic [7:0]         lost_cnt
);

  localparam logic [TIMER_W-1:0] RELOAD_RST = TIMER_W'(TIMER_DEFAULT);
  localparam logic [TIMER_W-1:0] ONE        = TIMER_W'(1);

  logic [TIMER_W-1:0] counter_reg;
  logic [TIMER_W-1:0] reload_reg;
  logic               c_tick;
  logic               c_pend_reg;
  logic               o_pend_reg;
  logic               c_lost;
  logic               o_lost;
  logic               s1_reg;
  logic               s2_reg;
  logic [7:0]         lost_cnt_reg;
  logic [1:0]         lost_inc;
  logic [8:0]         lost_sum;
  logic [1:0]         ban_vec;
  logic [1:0]         allow_vec;
  logic [1:0]         mask_vec;

  // A load suppresses the tick even when the counter sits at zero.
  assign c_tick = timer_en & ~timer_load & (counter_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_reg <= RELOAD_RST;
      reload_reg  <= RELOAD_RST;
    end else if (timer_load) begin
      counter_reg <= timer_data;
      reload_reg  <= timer_data;
    end else if (timer_en) begin
      counter_reg <= (counter_reg == '0) ? reload_reg : counter_reg - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= o_irq_in;
      s2_reg <= s1_reg;
    end
  end

`ifdef INT_LEVEL_EN
  // Level mode: the pending flag simply follows the synchronized line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_pend_reg <= 1'b0;
    else        o_pend_reg <= s2_reg;
  end

  assign o_lost = 1'b0;
`else
  logic s3_reg;
  logic o_tick_reg;

  // Edge pulse is registered so the request lands on the 4th edge after the pin rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_reg     <= 1'b0;
      o_tick_reg <= 1'b0;
      o_pend_reg <= 1'b0;
    end else begin
      s3_reg     <= s2_reg;
      o_tick_reg <= s2_reg & ~s3_reg;
      o_pend_reg <= o_tick_reg | (o_pend_reg & ~o_clear);
    end
  end

  assign o_lost = o_tick_reg & o_pend_reg & ~o_clear;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) c_pend_reg <= 1'b0;
    else        c_pend_reg <= c_tick | (c_pend_reg & ~c_clear);
  end

  assign c_lost   = c_tick & c_pend_reg & ~c_clear;
  assign lost_inc = {1'b0, c_lost} + {1'b0, o_lost};
  assign lost_sum = {1'b0, lost_cnt_reg} + {7'd0, lost_inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        lost_cnt_reg <= 8'd0;
    else if (lost_clr) lost_cnt_reg <= 8'd0;
    else               lost_cnt_reg <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
  end

  // Bit 0 is the c source, bit 1 the o source; ban beats allow.
  assign ban_vec   = {o_ban, c_ban};
  assign allow_vec = {o_allow, c_allow};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mask
      logic mask_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)              mask_reg <= 1'b0;
        else if (ban_vec[gi])    mask_reg <= 1'b1;
        else if (allow_vec[gi])  mask_reg <= 1'b0;
      end
      assign mask_vec[gi] = mask_reg;
    end
  endgenerate

  assign c_pend_raw   = c_pend_reg;
  assign o_pend_raw   = o_pend_reg;
  assign c_shield_out = c_pend_reg & ~mask_vec[0];
  assign o_shield_out = o_pend_reg & ~mask_vec[1];
  assign lost_cnt     = lost_cnt_reg;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Bench for int_req_ctrl: event-level reference model checked every cycle, plus directed literal checks.
module tb_int_req_ctrl;

  localparam int TW  = 16;
  localparam int DEF = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          timer_en = 1'b0;
  logic          timer_load = 1'b0;
  logic [TW-1:0] timer_data = '0;
  logic          o_irq_in = 1'b0;
  logic          c_clear = 1'b0;
  logic          o_clear = 1'b0;
  logic          c_ban = 1'b0;
  logic          c_allow = 1'b0;
  logic          o_ban = 1'b0;
  logic          o_allow = 1'b0;
  logic          lost_clr = 1'b0;
  logic          c_shield_out;
  logic          o_shield_out;
  logic          c_pend_raw;
  logic          o_pend_raw;
  logic [7:0]    lost_cnt;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  int_req_ctrl #(.TIMER_W(TW), .TIMER_DEFAULT(DEF)) dut (
    .clk(clk), .reset(reset), .timer_en(timer_en), .timer_load(timer_load),
    .timer_data(timer_data), .o_irq_in(o_irq_in), .c_clear(c_clear), .o_clear(o_clear),
    .c_ban(c_ban), .c_allow(c_allow), .o_ban(o_ban), .o_allow(o_allow), .lost_clr(lost_clr),
    .c_shield_out(c_shield_out), .o_shield_out(o_shield_out), .c_pend_raw(c_pend_raw),
    .o_pend_raw(o_pend_raw), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: timer ticks when the enabled-edge count since the last
  // load/reset hits reload mod (reload+1); o events come from input samples 3/4 edges back.
  int unsigned m_reload = DEF;
  int unsigned m_n      = 0;
  bit          m_cp = 0, m_op = 0, m_cm = 0, m_om = 0;
  int          m_lost = 0;
  bit [3:0]    m_hist = '0;
  bit          m_ct, m_ot;
  int          m_inc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reload = DEF; m_n = 0; m_cp = 0; m_op = 0; m_cm = 0; m_om = 0;
      m_lost = 0; m_hist = '0;
    end else begin
      m_ct  = 0;
      m_inc = 0;
      if (timer_load) begin
        m_reload = timer_data;
        m_n      = 0;
      end else if (timer_en) begin
        m_ct = (m_n % (m_reload + 1)) == m_reload;
        m_n++;
      end
      m_ot = m_hist[2] && !m_hist[3];
      if (m_ct && m_cp && !c_clear) m_inc++;
      m_cp = m_ct || (m_cp && !c_clear);
`ifdef INT_LEVEL_EN
      m_op = m_hist[1];
`else
      if (m_ot && m_op && !o_clear) m_inc++;
      m_op = m_ot || (m_op && !o_clear);
`endif
      if (lost_clr) m_lost = 0;
      else          m_lost = (m_lost + m_inc > 255) ? 255 : m_lost + m_inc;
      if (c_ban) m_cm = 1; else if (c_allow) m_cm = 0;
      if (o_ban) m_om = 1; else if (o_allow) m_om = 0;
      m_hist = {m_hist[2:0], o_irq_in};
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      total++;
      if (c_shield_out !== (m_cp && !m_cm) || o_shield_out !== (m_op && !m_om) ||
          c_pend_raw !== m_cp || o_pend_raw !== m_op || lost_cnt !== 8'(m_lost)) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got cs=%b os=%b cp=%b op=%b lost=%0d want cs=%b os=%b cp=%b op=%b lost=%0d",
                 $time, c_shield_out, o_shield_out, c_pend_raw, o_pend_raw, lost_cnt,
                 m_cp && !m_cm, m_op && !m_om, m_cp, m_op, m_lost);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("chk %s ok value=%0d", name, act);
    end
  endtask

  initial begin
    step(2);
    chk("reset_state", {c_shield_out, o_shield_out, c_pend_raw, o_pend_raw, lost_cnt}, 0);
    reset = 1'b1;

    // Timer period 4 with reload 3, then a clear colliding with a tick.
    timer_load = 1; timer_data = 3; step(1);
    timer_load = 0; timer_en = 1; step(3);
    chk("c_before_tick", c_pend_raw, 0);
    step(1);
    chk("c_first_tick", {c_pend_raw, c_shield_out}, 2'b11);
    step(3);
    c_clear = 1; step(1);
    chk("collide_pend_lost", {c_pend_raw, lost_cnt}, {1'b1, 8'd0});
    step(1);
    chk("c_cleared", c_pend_raw, 0);
    c_clear = 0; timer_en = 0;

`ifndef INT_LEVEL_EN
    // o edge latency, single request per level, then a lost o request.
    o_irq_in = 1; step(3);
    chk("o_before_4th", o_pend_raw, 0);
    step(1);
    chk("o_at_4th", {o_pend_raw, o_shield_out}, 2'b11);
    step(6); o_irq_in = 0;
    o_clear = 1; step(1); o_clear = 0; step(5);
    chk("o_no_rearm", o_pend_raw, 0);
    o_irq_in = 1; step(2); o_irq_in = 0; step(3);
    o_irq_in = 1; step(2); o_irq_in = 0; step(6);
    chk("o_lost", {o_pend_raw, lost_cnt}, {1'b1, 8'd1});
    o_clear = 1; step(1); o_clear = 0;
`else
    o_irq_in = 1; step(3);
    chk("o_level_hi", o_pend_raw, 1);
    o_irq_in = 0; step(3);
    chk("o_level_lo", o_pend_raw, 0);
`endif

    // Masking: pend visible but not shielded, ban beats allow, allow unmasks.
    c_ban = 1; step(1); c_ban = 0;
    timer_load = 1; timer_data = 3; step(1);
    timer_load = 0; timer_en = 1; step(4);
    chk("masked_pend", {c_pend_raw, c_shield_out}, 2'b10);
    timer_en = 0; c_ban = 1; c_allow = 1; step(1);
    chk("ban_wins", c_shield_out, 0);
    c_ban = 0; step(1);
    chk("allowed", c_shield_out, 1);
    c_allow = 0; c_clear = 1; step(1); c_clear = 0;

    // Lost counter saturation with reload 0, then clear overriding an increment.
    timer_load = 1; timer_data = 0; step(1);
    timer_load = 0; timer_en = 1; step(300);
    chk("lost_sat", {c_pend_raw, lost_cnt}, {1'b1, 8'd255});
    lost_clr = 1; step(1); lost_clr = 0;
    chk("lost_clr", lost_cnt, 0);
    timer_en = 0;

    // Reset mid-count: outputs drop at once, timer restarts from the default.
    timer_load = 1; timer_data = 5; step(1);
    timer_load = 0; timer_en = 1; step(3);
    #1 reset = 1'b0;
    #1 chk("async_reset", {c_shield_out, o_shield_out, c_pend_raw, o_pend_raw, lost_cnt}, 0);
    step(1);
    reset = 1'b1;
    step(DEF);
    chk("default_before", c_pend_raw, 0);
    step(1);
    chk("default_period", c_pend_raw, 1);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
